ser_arb39x13: RTL and testbench



---
 rtl/ser_pkg.sv | 35 +++
 rtl/ser_rr_arbiter.sv | 62 ++++++
 rtl/ser_arb39x13.sv | 122 ++++++++++++
 tb/tb_ser_arb39x13.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared constants, FSM state type and helpers for the 39-to-13 arbitrated serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   IN_W, OUT_W, NREQ  default word width, beat width and requester count
//   BEATS, SRC_W       beats per word and source index width for the defaults
//   MAX_REQ            widest requester set the helpers cover
//   state_t            serializer FSM states (IDLE, SEND)
//   idx_to_onehot      index to one-hot vector, MAX_REQ bits wide
package ser_pkg;

    localparam int IN_W    = 39;
    localparam int OUT_W   = 13;
    localparam int NREQ    = 4;
    localparam int BEATS   = IN_W / OUT_W;
    localparam int SRC_W   = $clog2(NREQ);
    localparam int MAX_REQ = 8;

    // Explicit single-bit encoding so the state register matches the older
    // localparam-based encodings (IDLE=0, SEND=1) seen in waveforms.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Callers slice the low NREQ bits; indices 0..MAX_REQ-1 are supported.
    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ser_rr_arbiter.sv
// Round-robin (or fixed-priority) requester selector for the serializer front end.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is allowed to be used.
//
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
// Default is round-robin, searching from lastGrant+1 and wrapping modulo NREQ.
//
// Ports:
//   req        per-requester request vector
//   lastGrant  index of the most recently served requester
//   grant      one-hot winner (all zero when nothing requests)
//   grantIdx   binary index of the winner (0 when nothing requests)
//   grantVld   at least one requester is asking
module ser_rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SRC_W-1:0] lastGrant,
    output logic [NREQ-1:0]  grant,
    output logic [SRC_W-1:0] grantIdx,
    output logic             grantVld
);
    import ser_pkg::*;

    logic [MAX_REQ-1:0] grant_oh;

    always_comb begin
        int         base;
        int         cand;
        logic [SRC_W-1:0] cand_idx;

        grantVld = 1'b0;
        grantIdx = '0;
        cand_idx = '0;
`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: always start the scan at requester 0.
        base = 0;
`else
        // Round-robin: the requester just served drops to lowest priority.
        base = int'(lastGrant) + 1;
`endif
        for (int k = 0; k < NREQ; k++) begin
            // base+k never exceeds 2*NREQ-1, so one conditional subtract wraps it.
            cand = base + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = SRC_W'(cand);
            if (!grantVld && req[cand_idx]) begin
                grantVld = 1'b1;
                grantIdx = cand_idx;
            end
        end
    end

    always_comb begin
        grant_oh = idx_to_onehot(3'(grantIdx));
        grant    = grantVld ? grant_oh[NREQ-1:0] : '0;
    end

endmodule

// File: rtl/ser_arb39x13.sv
// Arbitrated 39-to-13 serializer: grants one requester per word, emits BEATS narrow beats LSB first.
// Latency: word accepted in cycle N shows its first beat in cycle N+1; BEATS cycles/word at full rate.
// Backpressure: outReady low freezes the current beat; reqReady is only raised when the
//               serializer is idle or the final beat of the held word is being accepted.
//
// Build option: ARB_FIXED_PRIO_EN selects fixed priority in ser_rr_arbiter (default round-robin).
// IN_W must be an integer multiple of OUT_W; NREQ is limited to 2..8.
//
// Ports:
//   clk, rstN  clock and asynchronous active-low reset
//   reqValid   per-requester word valid
//   reqData    requester i word at [i*IN_W +: IN_W]
//   reqReady   one-hot accept; word i captured on reqValid[i] & reqReady[i]
//   outData    current beat (zero while idle)
//   outValid   beat valid
//   outReady   downstream accepts the beat
//   outSrc     requester that owns the current word
//   outLast    final beat of the word
//   busy       a word is held
module ser_arb39x13 #(
    parameter  int IN_W  = 39,
    parameter  int OUT_W = 13,
    parameter  int NREQ  = 4,
    localparam int BEATS = IN_W / OUT_W,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [NREQ-1:0]      reqValid,
    input  logic [NREQ*IN_W-1:0] reqData,
    output logic [NREQ-1:0]      reqReady,
    output logic [OUT_W-1:0]     outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [SRC_W-1:0]     outSrc,
    output logic                 outLast,
    output logic                 busy
);
    import ser_pkg::*;

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t           state;
    logic [IN_W-1:0]  shreg;
    logic [CNT_W-1:0] beat_cnt;
    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] out_src;

    logic [NREQ-1:0]  grant;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_vld;
    logic [IN_W-1:0]  grant_dat;

    logic             send_st;
    logic             last_beat;
    logic             beat_acc;
    logic             word_done;
    logic             arb_en;
    logic             word_acc;

    ser_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (reqValid),
        .lastGrant (last_grant),
        .grant     (grant),
        .grantIdx  (grant_idx),
        .grantVld  (grant_vld)
    );

    always_comb begin
        send_st   = (state == SEND);
        last_beat = send_st && (beat_cnt == CNT_W'(BEATS - 1));
        beat_acc  = send_st && outReady;
        word_done = beat_acc && last_beat;
        // Arbitration window: idle, or the cycle the final beat leaves, which
        // gives back-to-back words with no bubble.
        arb_en    = !send_st || word_done;
        word_acc  = arb_en && grant_vld;
        grant_dat = reqData[grant_idx*IN_W +: IN_W];
    end

    // rstN gates the accept so no requester sees a handshake while held in reset.
    always_comb begin
        reqReady = (rstN && arb_en) ? grant : '0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            shreg      <= '0;
            beat_cnt   <= '0;
            // Pointing at the top index makes requester 0 first in line after reset.
            last_grant <= SRC_W'(NREQ - 1);
            out_src    <= '0;
        end else if (word_acc) begin
            // New word: covers both the idle grant and the last-beat regrant.
            state      <= SEND;
            shreg      <= grant_dat;
            beat_cnt   <= '0;
            last_grant <= grant_idx;
            out_src    <= grant_idx;
        end else if (beat_acc) begin
            if (last_beat) begin
                state <= IDLE;
            end else begin
                shreg    <= shreg >> OUT_W;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Outputs come straight from registers, so they hold while outReady is low.
    always_comb begin
        outValid = send_st;
        busy     = send_st;
        outLast  = last_beat;
        outSrc   = out_src;
        outData  = send_st ? shreg[OUT_W-1:0] : '0;
    end

endmodule

// File: tb/tb_ser_arb39x13.sv
module tb_ser_arb39x13;

    localparam int NREQ  = 4;
    localparam int IN_W  = 39;
    localparam int OUT_W = 13;
    localparam int BEATS = 3;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic [NREQ-1:0]      reqValid;
    logic [NREQ*IN_W-1:0] reqData;
    logic [NREQ-1:0]      reqReady;
    logic [OUT_W-1:0]     outData;
    logic                 outValid;
    logic                 outReady;
    logic [1:0]           outSrc;
    logic                 outLast;
    logic                 busy;

    always #5 clk = ~clk;

    ser_arb39x13 dut (
        .clk      (clk),
        .rstN     (rstN),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqReady (reqReady),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .outSrc   (outSrc),
        .outLast  (outLast),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending beats of the word on the link, its owner,
    // and the most recently served requester.
    logic [OUT_W-1:0] bq[$];
    int               cur_src;
    int               lastg;
    logic [IN_W-1:0]  word [NREQ];
    logic [NREQ-1:0]  obs_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[IN_W-1:0];
    endfunction

    // One clock: drive inputs after the falling edge, compare outputs against
    // the model, then advance the model at the rising edge.
    task automatic step(input logic [NREQ-1:0] v, input logic r, input logic rst);
        int              w;
        int              idx;
        bit              ev;
        bit              el;
        bit              arb;
        logic [NREQ-1:0] er;
        @(negedge clk);
        rstN     = rst;
        reqValid = v;
        outReady = r;
        for (int i = 0; i < NREQ; i++) reqData[i*IN_W +: IN_W] = word[i];
        #1;
        obs_rdy = reqReady;
        if (!rst) begin
            chk("rst_valid", outValid, 0);
            chk("rst_ready", reqReady, 0);
            chk("rst_busy",  busy,     0);
            chk("rst_last",  outLast,  0);
            chk("rst_src",   outSrc,   0);
            chk("rst_data",  outData,  0);
            @(posedge clk);
            bq.delete();
            lastg   = NREQ - 1;
            cur_src = 0;
            return;
        end
        ev = (bq.size() != 0);
        el = (bq.size() == 1);
        w  = -1;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (lastg + 1 + k) % NREQ;
`endif
            if (w < 0 && v[idx]) w = idx;
        end
        arb = !ev || (r && el);
        er  = (arb && w >= 0) ? NREQ'(1 << w) : '0;
        chk("req_ready", reqReady, er);
        chk("out_valid", outValid, ev);
        chk("busy",      busy,     ev);
        if (ev) begin
            chk("out_data", outData, bq[0]);
            chk("out_src",  outSrc,  cur_src);
            chk("out_last", outLast, el);
        end
        @(posedge clk);
        if (ev && r) void'(bq.pop_front());
        if (arb && w >= 0) begin
            for (int b = 0; b < BEATS; b++) bq.push_back(word[w][b*OUT_W +: OUT_W]);
            cur_src = w;
            lastg   = w;
            word[w] = rnd_word();
        end
    endtask

    initial begin
        logic [IN_W-1:0] bpw;
        logic [IN_W-1:0] w0;
        logic [IN_W-1:0] w1s;
        logic [NREQ-1:0] rv;
        int              exp_src;

        rstN     = 1'b0;
        reqValid = '0;
        reqData  = '0;
        outReady = 1'b0;
        lastg    = NREQ - 1;
        cur_src  = 0;
        for (int i = 0; i < NREQ; i++) word[i] = rnd_word();

        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);

        // Single requester with a known word.
        word[0] = 39'h7F_FF00_1ABC;
        step(4'b0001, 1'b1, 1'b1);
        #2; chk("s1_beat1", outData, 13'h1ABC); chk("s1_src", outSrc, 0); chk("s1_last1", outLast, 0);
        step('0, 1'b1, 1'b1);
        #2; chk("s1_beat2", outData, 13'h1800); chk("s1_last2", outLast, 0);
        step('0, 1'b1, 1'b1);
        #2; chk("s1_beat3", outData, 13'h1FFF); chk("s1_last3", outLast, 1);
        step('0, 1'b1, 1'b1);
        #2; chk("s1_busy_fall", busy, 0); chk("s1_valid_fall", outValid, 0);

        // All requesters valid, sink always ready: order and no idle cycle.
        step('0, 1'b0, 1'b0);
        for (int j = 0; j < 15; j++) begin
            step(4'b1111, 1'b1, 1'b1);
            #2;
            chk("rr_busy", busy, 1);
            if (j % 3 == 0) begin
`ifdef ARB_FIXED_PRIO_EN
                exp_src = 0;
`else
                exp_src = (j / 3) % NREQ;
`endif
                chk("rr_src", outSrc, exp_src);
            end
        end
        for (int j = 0; j < 4; j++) step('0, 1'b1, 1'b1);

        // Backpressure on beat 2 while other requesters wait.
        bpw     = rnd_word();
        word[1] = bpw;
        step(4'b0010, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        #2; chk("bp_beat2", outData, bpw[25:13]);
        for (int j = 0; j < 5; j++) begin
            step(4'b0101, 1'b0, 1'b1);
            #2;
            chk("bp_hold_data", outData, bpw[25:13]);
            chk("bp_hold_src",  outSrc,  1);
            chk("bp_hold_last", outLast, 0);
            chk("bp_no_ready",  obs_rdy, 0);
        end
        step('0, 1'b1, 1'b1);
        #2; chk("bp_beat3", outData, bpw[38:26]); chk("bp_last", outLast, 1);
        step('0, 1'b1, 1'b1);

        // Reset in the middle of a word from requester 2.
        step(4'b0100, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b0);
        w0 = word[0];
        step(4'b0101, 1'b1, 1'b1);
        chk("rst_first_grant", obs_rdy, 4'b0001);
        #2; chk("rst_new_src", outSrc, 0); chk("rst_new_beat", outData, w0[12:0]);
        for (int j = 0; j < 3; j++) step('0, 1'b1, 1'b1);

        // Requester 1 appears exactly on the last-beat handshake of requester 0.
        step(4'b0001, 1'b1, 1'b1);
        w1s = word[1];
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b1);
        chk("rearb_ready", obs_rdy, 4'b0010);
        #2; chk("rearb_src", outSrc, 1); chk("rearb_valid", outValid, 1); chk("rearb_beat", outData, w1s[12:0]);
        for (int j = 0; j < 3; j++) step('0, 1'b1, 1'b1);

        // Random traffic with occasional resets.
        for (int j = 0; j < 800; j++) begin
            rv = NREQ'($urandom);
            step(rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
